// File: rtl/cruzamento_ctrl_pkg.sv
// Shared definitions for the two-road intersection controller.
//   - estado_e : FSM state encoding (all-red clearances, greens, yellows)
//   - *_DEF    : default interval lengths in clock cycles
//   - W_DEF    : default width of the interval timer
package cruzamento_ctrl_pkg;

  localparam int unsigned T_VERDE_DEF   = 8;
  localparam int unsigned T_AMARELO_DEF = 3;
  localparam int unsigned T_VERM_DEF    = 2;
  localparam int unsigned W_DEF         = 8;

  // VERM_BA: all-red after B's yellow, leads to A green.
  // VERM_AB: all-red after A's yellow, leads to B green.
  typedef enum logic [2:0] {
    VERM_BA = 3'd0,
    A_VERDE = 3'd1,
    A_AMAR  = 3'd2,
    VERM_AB = 3'd3,
    B_VERDE = 3'd4,
    B_AMAR  = 3'd5
  } estado_e;

endpackage

// File: rtl/temporizador.sv
// Interval down counter.
//   clk        : clock, rising edge
//   res        : asynchronous active-high reset, loads RST_VAL
//   load_i     : load load_val_i this cycle (new interval starts)
//   load_val_i : interval length minus one
//   timeout_o  : high while the count is zero (last cycle of the interval)
// The count saturates at zero so timeout_o stays high until the next load.
module temporizador #(
  parameter int unsigned W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         timeout_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == '0);

endmodule

// File: rtl/cruzamento_ctrl.sv
// Two-road traffic light controller with request latches.
//   clk, res                    : clock (rising edge), async active-high reset
//   CAR_A, CAR_B                : vehicle request per road (level or pulse)
//   VERDE_x/AMARELO_x/VERMELHO_x: lamps per road, Moore outputs of the state
//   TIMEOUT                     : last cycle of the current timed interval
//   PEND_A, PEND_B              : latched, not-yet-served requests
// Green rests on the current road until the minimum green has elapsed and the
// other road has a pending request; pending requests are never dropped.
module cruzamento_ctrl
  import cruzamento_ctrl_pkg::*;
#(
  parameter int unsigned T_VERDE   = T_VERDE_DEF,
  parameter int unsigned T_AMARELO = T_AMARELO_DEF,
  parameter int unsigned T_VERM    = T_VERM_DEF,
  parameter int unsigned W         = W_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic CAR_A,
  input  logic CAR_B,
  output logic VERDE_A,
  output logic AMARELO_A,
  output logic VERMELHO_A,
  output logic VERDE_B,
  output logic AMARELO_B,
  output logic VERMELHO_B,
  output logic TIMEOUT,
  output logic PEND_A,
  output logic PEND_B
);

  localparam logic [W-1:0] LdVerde   = W'(T_VERDE - 1);
  localparam logic [W-1:0] LdAmarelo = W'(T_AMARELO - 1);
  localparam logic [W-1:0] LdVerm    = W'(T_VERM - 1);

  estado_e      state_d, state_q;
  logic         pend_a_d, pend_a_q;
  logic         pend_b_d, pend_b_q;
  logic         timeout;
  logic         load;
  logic [W-1:0] load_val;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VERM_BA: if (timeout)            state_d = A_VERDE;
      A_VERDE: if (timeout && pend_b_q) state_d = A_AMAR;
      A_AMAR:  if (timeout)            state_d = VERM_AB;
      VERM_AB: if (timeout)            state_d = B_VERDE;
      B_VERDE: if (timeout && pend_a_q) state_d = B_AMAR;
      B_AMAR:  if (timeout)            state_d = VERM_BA;
      default:                         state_d = VERM_BA;
    endcase
  end

  // Timer restarts on every state change with the new state's interval.
  always_comb begin
    load     = (state_d != state_q);
    load_val = LdVerm;
    unique case (state_d)
      A_VERDE, B_VERDE: load_val = LdVerde;
      A_AMAR, B_AMAR:   load_val = LdAmarelo;
      default:          load_val = LdVerm;
    endcase
  end

  // Requests are ignored while their own road is green; entry into the
  // served green clears the latch and overrides a same-cycle set.
  always_comb begin
    pend_a_d = pend_a_q | (CAR_A && (state_q != A_VERDE));
    pend_b_d = pend_b_q | (CAR_B && (state_q != B_VERDE));
    if (state_d == A_VERDE && state_q != A_VERDE) pend_a_d = 1'b0;
    if (state_d == B_VERDE && state_q != B_VERDE) pend_b_d = 1'b0;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= VERM_BA;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  temporizador #(
    .W       (W),
    .RST_VAL (LdVerm)
  ) u_temporizador (
    .clk        (clk),
    .res        (res),
    .load_i     (load),
    .load_val_i (load_val),
    .timeout_o  (timeout)
  );

  always_comb begin
    VERDE_A    = 1'b0;
    AMARELO_A  = 1'b0;
    VERMELHO_A = 1'b0;
    VERDE_B    = 1'b0;
    AMARELO_B  = 1'b0;
    VERMELHO_B = 1'b0;
    unique case (state_q)
      A_VERDE: begin VERDE_A   = 1'b1; VERMELHO_B = 1'b1; end
      A_AMAR:  begin AMARELO_A = 1'b1; VERMELHO_B = 1'b1; end
      B_VERDE: begin VERDE_B   = 1'b1; VERMELHO_A = 1'b1; end
      B_AMAR:  begin AMARELO_B = 1'b1; VERMELHO_A = 1'b1; end
      default: begin VERMELHO_A = 1'b1; VERMELHO_B = 1'b1; end
    endcase
  end

  assign TIMEOUT = timeout;
  assign PEND_A  = pend_a_q;
  assign PEND_B  = pend_b_q;

endmodule

// File: tb/tb_cruzamento_ctrl.sv
// Bench for cruzamento_ctrl: a default-timed instance (8/3/2) and a minimum
// instance (1/1/1) share stimulus. A cycle model predicts both output vectors,
// which are queued when stimulus is driven and compared after the clock edge.
// Vector order: {VERDE_A, AMARELO_A, VERMELHO_A, VERDE_B, AMARELO_B,
//                VERMELHO_B, TIMEOUT, PEND_A, PEND_B}
module tb_cruzamento_ctrl;

  logic clk = 1'b0;
  logic res;
  logic car_a, car_b;

  logic va8, ya8, ra8, vb8, yb8, rb8, to8, pa8, pb8;
  logic va1, ya1, ra1, vb1, yb1, rb1, to1, pa1, pb1;

  always #5 clk = ~clk;

  cruzamento_ctrl u_dut8 (
    .clk(clk), .res(res), .CAR_A(car_a), .CAR_B(car_b),
    .VERDE_A(va8), .AMARELO_A(ya8), .VERMELHO_A(ra8),
    .VERDE_B(vb8), .AMARELO_B(yb8), .VERMELHO_B(rb8),
    .TIMEOUT(to8), .PEND_A(pa8), .PEND_B(pb8)
  );

  cruzamento_ctrl #(
    .T_VERDE(1), .T_AMARELO(1), .T_VERM(1), .W(4)
  ) u_dut1 (
    .clk(clk), .res(res), .CAR_A(car_a), .CAR_B(car_b),
    .VERDE_A(va1), .AMARELO_A(ya1), .VERMELHO_A(ra1),
    .VERDE_B(vb1), .AMARELO_B(yb1), .VERMELHO_B(rb1),
    .TIMEOUT(to1), .PEND_A(pa1), .PEND_B(pb1)
  );

  wire [8:0] obs8 = {va8, ya8, ra8, vb8, yb8, rb8, to8, pa8, pb8};
  wire [8:0] obs1 = {va1, ya1, ra1, vb1, yb1, rb1, to1, pa1, pb1};

  // st: 0 VERM_BA, 1 A_VERDE, 2 A_AMAR, 3 VERM_AB, 4 B_VERDE, 5 B_AMAR
  typedef struct packed {
    logic [2:0] st;
    int         n;   // cycles already spent in st
    logic       pa;
    logic       pb;
  } mdl_t;

  mdl_t m8, m1;
  logic [17:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic int dur(input logic [2:0] st, input int tv, input int ta, input int tr);
    if (st == 3'd1 || st == 3'd4) return tv;
    if (st == 3'd2 || st == 3'd5) return ta;
    return tr;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 3'd0;
    r.n  = 0;
    r.pa = 1'b0;
    r.pb = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic ca, input logic cb,
                                    input int tv, input int ta, input int tr);
    mdl_t r;
    logic to;
    logic [2:0] ns;
    to = (m.n >= dur(m.st, tv, ta, tr) - 1);
    ns = m.st;
    case (m.st)
      3'd0: if (to) ns = 3'd1;
      3'd1: if (to && m.pb) ns = 3'd2;
      3'd2: if (to) ns = 3'd3;
      3'd3: if (to) ns = 3'd4;
      3'd4: if (to && m.pa) ns = 3'd5;
      default: if (to) ns = 3'd0;
    endcase
    r.st = ns;
    r.n  = (ns != m.st) ? 0 : m.n + 1;
    r.pa = m.pa | (ca && m.st != 3'd1);
    r.pb = m.pb | (cb && m.st != 3'd4);
    if (ns == 3'd1 && m.st != 3'd1) r.pa = 1'b0;
    if (ns == 3'd4 && m.st != 3'd4) r.pb = 1'b0;
    return r;
  endfunction

  function automatic logic [8:0] mdl_out(input mdl_t m, input int tv, input int ta, input int tr);
    logic [8:0] o;
    o = '0;
    case (m.st)
      3'd1: begin o[8] = 1'b1; o[3] = 1'b1; end
      3'd2: begin o[7] = 1'b1; o[3] = 1'b1; end
      3'd4: begin o[5] = 1'b1; o[6] = 1'b1; end
      3'd5: begin o[4] = 1'b1; o[6] = 1'b1; end
      default: begin o[6] = 1'b1; o[3] = 1'b1; end
    endcase
    o[2] = (m.n >= dur(m.st, tv, ta, tr) - 1);
    o[1] = m.pa;
    o[0] = m.pb;
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_expected();
    sb_q.push_back({mdl_out(m8, 8, 3, 2), mdl_out(m1, 1, 1, 1)});
  endtask

  task automatic compare_head(input string tag);
    logic [17:0] e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
    end else begin
      n_checks--;
      e = sb_q.pop_front();
      check_eq({tag, "/t8"}, obs8, e[17:9]);
      check_eq({tag, "/t1"}, obs1, e[8:0]);
    end
  endtask

  // Called at posedge+1; drives inputs, predicts next edge, compares after it.
  task automatic step(input logic ca, input logic cb, input string tag);
    car_a = ca;
    car_b = cb;
    m8 = mdl_step(m8, ca, cb, 8, 3, 2);
    m1 = mdl_step(m1, ca, cb, 1, 1, 1);
    push_expected();
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  // Asserts reset mid-cycle; outputs must change without waiting for an edge.
  task automatic apply_reset();
    car_a = 1'b0;
    car_b = 1'b0;
    #2;
    res = 1'b1;
    #1;
    m8 = mdl_reset();
    m1 = mdl_reset();
    push_expected();
    compare_head("rst_async");
    @(posedge clk);
    #1;
    push_expected();
    compare_head("rst_hold");
    res = 1'b0;
  endtask

  initial begin
    int guard;
    res   = 1'b1;
    car_a = 1'b0;
    car_b = 1'b0;
    m8 = mdl_reset();
    m1 = mdl_reset();
    @(posedge clk);
    #1;

    // Reset release with no traffic: all-red then green resting on A.
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "idle");

    // One-cycle CAR_B pulse during the third cycle of A green.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "pre_pulse");
    step(1'b0, 1'b1, "pulse_b");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "serve_b");

    // Both roads requesting continuously: strict alternation.
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, "both");

    // Reset in the middle of A yellow, then restart timing.
    apply_reset();
    guard = 0;
    while (m8.st != 3'd2 && guard < 40) begin
      step(1'b1, 1'b1, "to_amar");
      guard++;
    end
    check_eq("reach_a_amar", {6'd0, m8.st}, 9'd2);
    step(1'b0, 1'b0, "in_amar");
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "restart");

    // CAR_A on the entry edge into A green and the first A-green cycle.
    apply_reset();
    step(1'b0, 1'b0, "verm1");
    step(1'b1, 1'b0, "entry_a");
    step(1'b1, 1'b0, "first_a");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "after_a");

    // Random request traffic.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cruzamento_ctrl.md
CRUZAMENTO_CTRL -- requirements
Module: cruzamento_ctrl

Interface
REQ-001 Parameter T_VERDE, default 8, minimum green cycles per road (>=1).
REQ-002 Parameter T_AMARELO, default 3, exact yellow cycles (>=1).
REQ-003 Parameter T_VERM, default 2, exact all-red clearance cycles (>=1).
REQ-004 Parameter W, default 8, timer width; all durations SHALL be < 2**W.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 res  in  1  reset, asynchronous, active-high.
REQ-007 CAR_A, CAR_B  in  1 each  vehicle present/request on road A / road B (level or single-cycle pulse).
REQ-008 VERDE_A, AMARELO_A, VERMELHO_A  out  1 each  road A lamps.
REQ-009 VERDE_B, AMARELO_B, VERMELHO_B  out  1 each  road B lamps.
REQ-010 TIMEOUT  out  1  high in the last cycle of the current timed interval.
REQ-011 PEND_A, PEND_B  out  1 each  latched pending request per road.

Function
REQ-012 FSM states: VERM_BA, A_VERDE, A_AMAR, VERM_AB, B_VERDE, B_AMAR; lamps SHALL be Moore outputs of state only.
REQ-013 Lamps: A_VERDE -> VERDE_A+VERMELHO_B; A_AMAR -> AMARELO_A+VERMELHO_B; B_VERDE -> VERDE_B+VERMELHO_A; B_AMAR -> AMARELO_B+VERMELHO_A; VERM_* -> both VERMELHO.
REQ-014 Exactly one lamp per road SHALL be on in every cycle; VERDE_A and VERDE_B SHALL never be high together.
REQ-015 Timer: on each state entry loads duration-1 and decrements once per cycle; TIMEOUT=1 when value is 0; timer holds at 0.
REQ-016 VERM_BA -> A_VERDE on TIMEOUT; VERM_AB -> B_VERDE on TIMEOUT (each lasts exactly T_VERM cycles).
REQ-017 A_AMAR -> VERM_AB on TIMEOUT; B_AMAR -> VERM_BA on TIMEOUT (exactly T_AMARELO cycles).
REQ-018 A_VERDE -> A_AMAR when TIMEOUT and PEND_B; otherwise stays (green rests on A indefinitely).
REQ-019 B_VERDE -> B_AMAR when TIMEOUT and PEND_A; otherwise stays.
REQ-020 PEND_A set by CAR_A=1 in any state except A_VERDE; cleared on entry to A_VERDE; CAR_A during A_VERDE ignored. Symmetric for PEND_B/B_VERDE.
REQ-021 Set and clear in same cycle: clear wins (entry into the served green).
REQ-022 Request arriving before minimum green expires SHALL be held and served on TIMEOUT; no request lost.
REQ-023 Both PEND_A and PEND_B high: roads alternate strictly; no road gets two consecutive greens while the other is pending.
REQ-024 Inputs sampled only on rising clk; no combinational path from CAR_x to any output.

Reset
REQ-025 res=1 SHALL immediately force state VERM_BA, timer T_VERM-1, PEND_A=PEND_B=0, outputs VERMELHO_A=VERMELHO_B=1, all others 0, TIMEOUT=0 (unless T_VERM=1).
REQ-026 Reset asserted mid-cycle in any state (including green/yellow) SHALL abort the sequence with no intermediate lamp state.
REQ-027 After res deasserts, first A_VERDE SHALL begin exactly T_VERM rising edges later.

Structure
REQ-028 Shared package SHALL hold state enumeration, default durations, and W.
REQ-029 Down counter with load/TIMEOUT SHALL be sub-module temporizador; FSM and request latches stay in cruzamento_ctrl.

Verification
REQ-030 Reset release, no cars -> 2 cycles all-red, then VERDE_A held indefinitely, PEND_x=0.
REQ-031 CAR_B pulse 1 cycle at cycle 3 of A_VERDE -> PEND_B=1, A green 8 cycles total, A_AMAR 3, all-red 2, VERDE_B, PEND_B=0.
REQ-032 CAR_A and CAR_B held high -> repeating 8 green A, 3, 2, 8 green B, 3, 2; never both green.
REQ-033 res asserted during A_AMAR -> same cycle both red, PEND cleared; restart per REQ-027.
REQ-034 CAR_A pulse in same cycle as entry into A_VERDE -> PEND_A stays 0.
REQ-035 T_VERDE=T_AMARELO=T_VERM=1 -> each timed state lasts one cycle, TIMEOUT constant 1, lamp exclusivity holds.
